// File: rtl/maxima_frame_scheduler.sv
// Frame sequencer for the 16-peak maxima finder.
// Loads one frame of FFT magnitude bins into the finder, padding short frames
// and dropping the tail of long ones. It then starts the finder, waits for the
// rising edge of its active flag and snapshots the peaks. Finally it streams
// the peaks downstream, largest first, over a valid/ready handshake.
module maxima_frame_scheduler #(
   parameter int N_BINS  = 512,
   parameter int N_PEAKS = 16,
   parameter int DATA_W  = 25,
   parameter int TIMEOUT = 16384
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      bin_valid,
   input  logic [DATA_W-1:0]         bin_data,
   input  logic                      bin_last,
   output logic                      bin_ready,
   output logic                      fm_reset,
   output logic                      fm_load,
   output logic [DATA_W-1:0]         fm_data,
   output logic                      fm_start,
   input  logic                      fm_active,
   input  logic [N_PEAKS*DATA_W-1:0] fm_peaks,
   output logic                      peak_valid,
   output logic [DATA_W-1:0]         peak_data,
   output logic [3:0]                peak_idx,
   output logic                      peak_last,
   input  logic                      peak_ready,
   output logic                      busy,
   output logic [15:0]               frame_count,
   output logic [7:0]                drop_count,
   output logic                      err_len,
   output logic                      err_timeout
);

   localparam int CNT_W = $clog2(N_BINS + 1);
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] LAST_BIN  = CNT_W'(N_BINS - 1);
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
   localparam logic [3:0]       LAST_PEAK = 4'(N_PEAKS - 1);

   typedef enum logic [3:0] {
      S_IDLE, S_CLEAR, S_LOAD, S_PAD, S_DISCARD, S_START, S_WAIT, S_CAPTURE, S_DRAIN
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;          // finder loads issued this frame
   logic [TMR_W-1:0]    tmr_q, tmr_d;          // cycles spent in WAIT
   logic                act_prev_q, act_prev_d;
   logic                fm_reset_q, fm_reset_d;
   logic                fm_load_q, fm_load_d;
   logic [DATA_W-1:0]   fm_data_q, fm_data_d;
   logic                fm_start_q, fm_start_d;
   logic [3:0]          idx_q, idx_d;
   logic [DATA_W-1:0]   snap_q [N_PEAKS];
   logic [DATA_W-1:0]   snap_d [N_PEAKS];
   logic [15:0]         frame_cnt_q, frame_cnt_d;
   logic [7:0]          drop_cnt_q, drop_cnt_d;
   logic                err_len_q, err_len_d;
   logic                err_to_q, err_to_d;
   logic [DATA_W-1:0]   peaks_w [N_PEAKS];
   logic                ready_w;
   logic                valid_w;

   // Unpack the finder result bus; peak k lives at [k*DATA_W +: DATA_W].
   for (genvar gi = 0; gi < N_PEAKS; gi++) begin : g_unpack
      assign peaks_w[gi] = fm_peaks[gi*DATA_W +: DATA_W];
   end

   // Next-state, counters and registered finder strobes.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      tmr_d       = tmr_q;
      act_prev_d  = fm_active;
      fm_reset_d  = 1'b0;
      fm_load_d   = 1'b0;
      fm_data_d   = '0;
      fm_start_d  = 1'b0;
      idx_d       = idx_q;
      snap_d      = snap_q;
      frame_cnt_d = frame_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      err_len_d   = err_len_q;
      err_to_d    = err_to_q;
      ready_w     = 1'b0;
      valid_w     = 1'b0;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (bin_valid) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            cnt_d   = '0;
            state_d = S_LOAD;
         end
         S_LOAD: begin
            ready_w = 1'b1;
            if (bin_valid) begin
               fm_load_d = 1'b1;
               fm_data_d = bin_data;
               cnt_d     = cnt_q + 1'b1;
               if (cnt_q == LAST_BIN) begin
                  if (bin_last) begin
                     state_d = S_START;
                  end else begin
                     err_len_d = 1'b1;
                     state_d   = S_DISCARD;
                  end
               end else if (bin_last) begin
                  err_len_d = 1'b1;
                  state_d   = S_PAD;
               end
            end
         end
         S_PAD: begin
            // Zero-fill so the finder always sees a full frame.
            fm_load_d = 1'b1;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == LAST_BIN) state_d = S_START;
         end
         S_DISCARD: begin
            ready_w = 1'b1;
            if (bin_valid && bin_last) state_d = S_START;
         end
         S_START: begin
            // fm_start is registered, so it lands one cycle after the last fm_load.
            fm_start_d = 1'b1;
            tmr_d      = '0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            tmr_d = tmr_q + 1'b1;
            if (fm_active && !act_prev_q) begin
               state_d = S_CAPTURE;
            end else if (tmr_q == TMR_LAST) begin
               err_to_d = 1'b1;
               if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 8'd1;
               state_d = S_IDLE;
            end
         end
         S_CAPTURE: begin
            snap_d  = peaks_w;
            idx_d   = '0;
            state_d = S_DRAIN;
         end
         S_DRAIN: begin
            valid_w = 1'b1;
            if (peak_ready) begin
               if (idx_q == LAST_PEAK) begin
                  idx_d = '0;
                  if (frame_cnt_q != '1) frame_cnt_d = frame_cnt_q + 16'd1;
                  state_d = S_IDLE;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Finder reset is aligned with the CLEAR state itself.
      fm_reset_d = (state_d == S_CLEAR);
   end

   // State and datapath registers; reset discards any frame in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         tmr_q       <= '0;
         act_prev_q  <= 1'b0;
         fm_reset_q  <= 1'b1;
         fm_load_q   <= 1'b0;
         fm_data_q   <= '0;
         fm_start_q  <= 1'b0;
         idx_q       <= '0;
         snap_q      <= '{default: '0};
         frame_cnt_q <= '0;
         drop_cnt_q  <= '0;
         err_len_q   <= 1'b0;
         err_to_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tmr_q       <= tmr_d;
         act_prev_q  <= act_prev_d;
         fm_reset_q  <= fm_reset_d;
         fm_load_q   <= fm_load_d;
         fm_data_q   <= fm_data_d;
         fm_start_q  <= fm_start_d;
         idx_q       <= idx_d;
         snap_q      <= snap_d;
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
         err_len_q   <= err_len_d;
         err_to_q    <= err_to_d;
      end
   end

   assign bin_ready   = ready_w;
   assign fm_reset    = fm_reset_q;
   assign fm_load     = fm_load_q;
   assign fm_data     = fm_data_q;
   assign fm_start    = fm_start_q;
   assign peak_valid  = valid_w;
   assign peak_data   = valid_w ? snap_q[idx_q] : '0;
   assign peak_idx    = valid_w ? idx_q : 4'd0;
   assign peak_last   = valid_w && (idx_q == LAST_PEAK);
   assign busy        = (state_q != S_IDLE);
   assign frame_count = frame_cnt_q;
   assign drop_count  = drop_cnt_q;
   assign err_len     = err_len_q;
   assign err_timeout = err_to_q;

endmodule

// File: tb/tb_maxima_frame_scheduler.sv
// Directed bench for maxima_frame_scheduler: full, stalled, short, long,
// timed-out and reset-interrupted frames against hand-computed expectations.
module tb_maxima_frame_scheduler;
   localparam int N_BINS  = 512;
   localparam int N_PEAKS = 16;
   localparam int DATA_W  = 25;
   localparam int TIMEOUT = 16384;

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      bin_valid, bin_last, bin_ready;
   logic [DATA_W-1:0]         bin_data;
   logic                      fm_reset, fm_load, fm_start, fm_active;
   logic [DATA_W-1:0]         fm_data;
   logic [N_PEAKS*DATA_W-1:0] fm_peaks;
   logic                      peak_valid, peak_last, peak_ready, busy;
   logic [DATA_W-1:0]         peak_data;
   logic [3:0]                peak_idx;
   logic [15:0]               frame_count;
   logic [7:0]                drop_count;
   logic                      err_len, err_timeout;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_pk [N_PEAKS];

   // finder-side activity seen on the falling edge
   int mon_load = 0, mon_zero = 0, mon_start = 0, mon_both = 0, mon_freset = 0;
   logic [DATA_W-1:0] mon_last_data = '0;

   always #5 clk = ~clk;

   maxima_frame_scheduler #(
      .N_BINS(N_BINS), .N_PEAKS(N_PEAKS), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .reset(reset),
      .bin_valid(bin_valid), .bin_data(bin_data), .bin_last(bin_last), .bin_ready(bin_ready),
      .fm_reset(fm_reset), .fm_load(fm_load), .fm_data(fm_data), .fm_start(fm_start),
      .fm_active(fm_active), .fm_peaks(fm_peaks),
      .peak_valid(peak_valid), .peak_data(peak_data), .peak_idx(peak_idx),
      .peak_last(peak_last), .peak_ready(peak_ready),
      .busy(busy), .frame_count(frame_count), .drop_count(drop_count),
      .err_len(err_len), .err_timeout(err_timeout)
   );

   // Count finder strobes once per cycle.
   always @(negedge clk) begin
      if (fm_load) begin
         mon_load++;
         if (fm_data == '0) mon_zero++;
         mon_last_data = fm_data;
      end
      if (fm_start) mon_start++;
      if (fm_load && fm_start) mon_both++;
      if (fm_reset) mon_freset++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_state();
      check_eq("rst_bin_ready", 32'(bin_ready), 0);
      check_eq("rst_fm_reset", 32'(fm_reset), 1);
      check_eq("rst_fm_load", 32'(fm_load), 0);
      check_eq("rst_fm_data", 32'(fm_data), 0);
      check_eq("rst_fm_start", 32'(fm_start), 0);
      check_eq("rst_peak_valid", 32'(peak_valid), 0);
      check_eq("rst_peak_data", 32'(peak_data), 0);
      check_eq("rst_peak_idx", 32'(peak_idx), 0);
      check_eq("rst_peak_last", 32'(peak_last), 0);
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_frame_count", 32'(frame_count), 0);
      check_eq("rst_drop_count", 32'(drop_count), 0);
      check_eq("rst_err_len", 32'(err_len), 0);
      check_eq("rst_err_timeout", 32'(err_timeout), 0);
   endtask

   task automatic set_peaks(input int top);
      for (int k = 0; k < N_PEAKS; k++) begin
         fm_peaks[k*DATA_W +: DATA_W] = DATA_W'(top - k);
         exp_pk[k] = top - k;
      end
   endtask

   // Bin i carries base+i; bin_last marks index last_at (-1 for none).
   task automatic send_frame(input int n, input int last_at, input int base);
      for (int i = 0; i < n; i++) begin
         int g;
         g = 0;
         bin_valid = 1'b1;
         bin_data  = DATA_W'(base + i);
         bin_last  = (i == last_at);
         while (!bin_ready && g < 100) begin
            @(negedge clk);
            g++;
         end
         if (g >= 100) begin
            check_eq("bin_accept", 32'(bin_ready), 1);
            break;
         end
         @(negedge clk);
      end
      bin_valid = 1'b0;
      bin_last  = 1'b0;
   endtask

   task automatic wait_start();
      int g;
      g = 0;
      while (!fm_start && g < 1000) begin
         @(negedge clk);
         g++;
      end
      check_eq("start_seen", 32'(fm_start), 1);
   endtask

   task automatic drain(input int stall_idx);
      for (int k = 0; k < N_PEAKS; k++) begin
         int g;
         g = 0;
         while (!peak_valid && g < 100) begin
            @(negedge clk);
            g++;
         end
         check_eq("peak_idx", 32'(peak_idx), 32'(k));
         check_eq("peak_data", 32'(peak_data), 32'(exp_pk[k]));
         check_eq("peak_last", 32'(peak_last), 32'(k == N_PEAKS - 1));
         $display("peak idx=%0d data=%0d last=%0b", peak_idx, peak_data, peak_last);
         if (k == stall_idx) begin
            int bad;
            bad = 0;
            peak_ready = 1'b0;
            repeat (10) begin
               @(negedge clk);
               if (!peak_valid || peak_idx !== 4'(k) || peak_data !== DATA_W'(exp_pk[k])) bad++;
            end
            check_eq("stall_hold", 32'(bad), 0);
            peak_ready = 1'b1;
            @(negedge clk);
            check_eq("stall_resume", 32'(peak_idx), 32'(k + 1));
         end else begin
            @(negedge clk);
         end
      end
   endtask

   task automatic do_frame(input int n, input int last_at, input int base, input int top,
                           input int stall_idx, input bit pre_high, input int exp_fc,
                           input int exp_zero);
      int ld0, z0, st0, bo0, fr0;
      ld0 = mon_load; z0 = mon_zero; st0 = mon_start; bo0 = mon_both; fr0 = mon_freset;
      set_peaks(top);
      if (!pre_high) fm_active = 1'b0;
      send_frame(n, last_at, base);
      if (n == N_BINS && last_at == N_BINS - 1) begin
         check_eq("lat_load", 32'(fm_load), 1);
         check_eq("lat_nostart", 32'(fm_start), 0);
         @(negedge clk);
         check_eq("lat_start", 32'(fm_start), 1);
      end
      wait_start();
      // offer a bin during WAIT: it must be held off
      bin_valid = 1'b1;
      bin_data  = '1;
      repeat (4) @(negedge clk);
      check_eq("wait_backpressure", 32'(bin_ready), 0);
      bin_valid = 1'b0;
      if (pre_high) begin
         check_eq("prehigh_no_capture", 32'(peak_valid), 0);
         check_eq("prehigh_busy", 32'(busy), 1);
         fm_active = 1'b0;
         @(negedge clk);
      end
      fm_active = 1'b1;
      @(negedge clk);
      check_eq("cap_lat1", 32'(peak_valid), 0);
      @(negedge clk);
      check_eq("cap_lat2", 32'(peak_valid), 1);
      fm_peaks = '1;  // snapshot must not follow the finder bus
      drain(stall_idx);
      check_eq("drained_valid", 32'(peak_valid), 0);
      check_eq("frame_count", 32'(frame_count), 32'(exp_fc));
      check_eq("n_load", 32'(mon_load - ld0), 32'(N_BINS));
      check_eq("n_zero_load", 32'(mon_zero - z0), 32'(exp_zero));
      check_eq("n_start", 32'(mon_start - st0), 1);
      check_eq("load_start_overlap", 32'(mon_both - bo0), 0);
      check_eq("n_fm_reset", 32'(mon_freset - fr0), 1);
      $display("frame bins=%0d last_at=%0d frame_count=%0d err_len=%0b", n, last_at, frame_count, err_len);
   endtask

   initial begin
      int cnt;
      reset      = 1'b0;
      bin_valid  = 1'b0;
      bin_data   = '0;
      bin_last   = 1'b0;
      fm_active  = 1'b0;
      fm_peaks   = '0;
      peak_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_state();
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // full frame 0..511, finder reports 511..496, stall at idx 3
      do_frame(512, 511, 0, 511, 3, 1'b0, 1, 1);
      check_eq("err_len_clean", 32'(err_len), 0);

      // short frame: last on bin 99 -> 412 zero pads
      do_frame(100, 99, 1, 900, -1, 1'b0, 2, 412);
      check_eq("err_len_short", 32'(err_len), 1);
      check_eq("pad_last_data", 32'(mon_last_data), 0);

      // long frame: 520 bins, tail dropped; finder active still high at WAIT entry
      do_frame(520, 519, 1, 700, -1, 1'b1, 3, 0);
      check_eq("long_last_loaded", 32'(mon_last_data), 512);
      check_eq("err_len_long", 32'(err_len), 1);

      // finder never completes
      fm_active = 1'b0;
      set_peaks(50);
      send_frame(512, 511, 0);
      wait_start();
      cnt = 0;
      while (busy && cnt < 20000) begin
         @(negedge clk);
         cnt++;
      end
      check_eq("timeout_cycles", 32'(cnt), 32'(TIMEOUT));
      check_eq("err_timeout", 32'(err_timeout), 1);
      check_eq("drop_count", 32'(drop_count), 1);
      check_eq("fc_after_drop", 32'(frame_count), 3);
      $display("frame timed out after %0d wait cycles drop_count=%0d", cnt, drop_count);
      do_frame(512, 511, 0, 300, -1, 1'b0, 4, 1);

      // reset while loading bin 200
      send_frame(200, -1, 1);
      bin_valid = 1'b1;
      bin_data  = DATA_W'(201);
      reset     = 1'b0;
      @(negedge clk);
      check_reset_state();
      bin_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      do_frame(512, 511, 0, 511, -1, 1'b0, 1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
